// File: rtl/dna_port_arbiter.sv
// Round-robin arbiter owning the device DNA port: boot capture, per-requester DNA compare.
// Optional build macro DNA_PORT_ARBITER_CACHE_EN: serve requests from the boot capture.

// Behavioural DNA port: READ loads the ID, SHIFT moves it out MSB first on dout.
module dna_port_arbiter_dna_model #(
    parameter int unsigned          DNA_W         = 57,
    parameter logic [DNA_W-1:0]     SIM_DNA_VALUE = 57'h000094c94546a85c
) (
    input  logic clk,
    input  logic read,
    input  logic shift,
    input  logic din,
    output logic dout
);
    logic [DNA_W-1:0] dna_sr;

    always_ff @(posedge clk) begin
        if (read)
            dna_sr <= SIM_DNA_VALUE;
        else if (shift)
            dna_sr <= {dna_sr[DNA_W-2:0], din};
    end

    assign dout = dna_sr[DNA_W-1];
endmodule

module dna_port_arbiter #(
    parameter int unsigned          NUM_REQ = 2,
    parameter int unsigned          DNA_W   = 57,
    parameter logic [DNA_W-1:0]     SIM_DNA = 57'h000094c94546a85c
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DNA_W-1:0]   expected_dna,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         match,
    output logic [DNA_W-1:0]           dna_value,
    output logic                       dna_valid,
    output logic                       busy
);
    localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [5:0]  LAST_BIT = 6'(DNA_W - 1);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CMP,
        ST_ACK
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   owner;
    logic               owner_valid;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [5:0]         cnt;
    logic               dna_read;
    logic               dna_shift;
    logic               dna_dout;
    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    int unsigned        scan_idx;

    dna_port_arbiter_dna_model #(
        .DNA_W         (DNA_W),
        .SIM_DNA_VALUE (SIM_DNA)
    ) u_dna_port (
        .clk   (clk),
        .read  (dna_read),
        .shift (dna_shift),
        .din   (1'b0),
        .dout  (dna_dout)
    );

    // First pending request at or after the round-robin pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = (32'(rr_ptr) + i) % NUM_REQ;
            if (!grant_found && req[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(scan_idx);
            end
        end
    end

    assign ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_BOOT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        dna_read  = 1'b0;
        dna_shift = 1'b0;
        ack       = '0;
        case (state)
            ST_BOOT:  state_nxt = ST_LOAD;
            ST_IDLE: begin
                if (grant_found) begin
`ifdef DNA_PORT_ARBITER_CACHE_EN
                    state_nxt = dna_valid ? ST_CMP : ST_LOAD;
`else
                    state_nxt = ST_LOAD;
`endif
                end
            end
            ST_LOAD: begin
                dna_read  = 1'b1;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Last sample takes bit 0, so the port must not shift again.
                dna_shift = (cnt != LAST_BIT);
                if (cnt == LAST_BIT)
                    state_nxt = owner_valid ? ST_CMP : ST_IDLE;
            end
            ST_CMP:   state_nxt = ST_ACK;
            ST_ACK: begin
                ack[owner] = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default:  state_nxt = ST_BOOT;
        endcase
    end

    // Reset is asynchronous, so busy is masked directly to stay low while it is held.
    assign busy = (state != ST_IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner       <= '0;
            owner_valid <= 1'b0;
            rr_ptr      <= '0;
            cnt         <= '0;
            dna_value   <= '0;
            dna_valid   <= 1'b0;
            match       <= '0;
        end else begin
            case (state)
                ST_BOOT: owner_valid <= 1'b0;
                ST_IDLE: begin
                    if (grant_found) begin
                        owner       <= grant_idx;
                        owner_valid <= 1'b1;
                        rr_ptr      <= ptr_next;
                        if (state_nxt == ST_LOAD)
                            dna_valid <= 1'b0;
                    end
                end
                ST_LOAD: cnt <= '0;
                ST_SHIFT: begin
                    dna_value[LAST_BIT - cnt] <= dna_dout;
                    cnt                       <= cnt + 6'd1;
                    if (cnt == LAST_BIT)
                        dna_valid <= 1'b1;
                end
                ST_CMP:  match[owner] <= (dna_value == expected_dna[owner*DNA_W +: DNA_W]);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dna_port_arbiter.sv
// Scoreboard bench for dna_port_arbiter; expected latency follows DNA_PORT_ARBITER_CACHE_EN.
module tb_dna_port_arbiter;
    localparam int          NR  = 2;
    localparam int          W   = 57;
    localparam logic [56:0] SIM = 57'h000094c94546a85c;
`ifdef DNA_PORT_ARBITER_CACHE_EN
    localparam int LAT      = 2;
    localparam int READS    = 1;
`else
    localparam int LAT      = 60;
    localparam int READS    = 2;
`endif
    localparam int BOOT_EDGES = 59;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*W-1:0]   expected_dna = '0;
    logic [NR-1:0]     ack;
    logic [NR-1:0]     match;
    logic [W-1:0]      dna_value;
    logic              dna_valid;
    logic              busy;

    dna_port_arbiter #(.NUM_REQ(NR)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .expected_dna (expected_dna),
        .ack          (ack),
        .match        (match),
        .dna_value    (dna_value),
        .dna_valid    (dna_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   idx;
        logic m;
    } exp_t;

    exp_t          sb[$];
    logic [NR-1:0] model_match = '0;
    int            n_checks    = 0;
    int            n_fail      = 0;
    int            n_acks      = 0;
    int            rd_cycles   = 0;
    int            sh_cycles   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            if (dut.dna_read)  rd_cycles++;
            if (dut.dna_shift) sh_cycles++;
        end
        if (ack != '0) begin
            n_acks++;
            if (sb.size() == 0) begin
                check_eq("ack_unexpected", 64'(ack), 64'd0);
            end else begin
                e = sb.pop_front();
                model_match[e.idx] = e.m;
                check_eq("ack_onehot", 64'(ack), 64'd1 << e.idx);
                check_eq("match", 64'(match), 64'(model_match));
            end
        end
    end

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check_eq({tag, "_idle_timeout"}, 64'(busy), 64'd0);
    endtask

    // Counts rising edges from the first one after the call until an ack appears.
    task automatic wait_ack(input int base, input int limit, output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #2;
            edges++;
        end while (n_acks == base && edges < limit);
    endtask

    task automatic do_req(input int idx, input logic [56:0] exp_val, input logic exp_m,
                          input string tag);
        int base;
        int edges;
        wait_idle(tag);
        base = n_acks;
        expected_dna[idx*W +: W] = exp_val;
        req[idx] = 1'b1;
        sb.push_back('{idx, exp_m});
        wait_ack(base, 300, edges);
        req[idx] = 1'b0;
        check_eq({tag, "_latency"}, 64'(edges), 64'(LAT));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ack"},       64'(ack),           64'd0);
        check_eq({tag, "_match"},     64'(match),         64'd0);
        check_eq({tag, "_dna_value"}, 64'(dna_value),     64'd0);
        check_eq({tag, "_dna_valid"}, 64'(dna_valid),     64'd0);
        check_eq({tag, "_busy"},      64'(busy),          64'd0);
        check_eq({tag, "_read"},      64'(dut.dna_read),  64'd0);
        check_eq({tag, "_shift"},     64'(dut.dna_shift), 64'd0);
    endtask

    initial begin
        int edges;
        int base;

        // Boot read with no requests
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        rd_cycles = 0;
        sh_cycles = 0;
        edges = 0;
        do begin
            @(posedge clk);
            #2;
            edges++;
        end while (!dna_valid && edges < 300);
        check_eq("boot_valid_edges", 64'(edges), 64'(BOOT_EDGES));
        check_eq("boot_dna_value", 64'(dna_value), 64'(SIM));
        check_eq("boot_read_cycles", 64'(rd_cycles), 64'd1);
        check_eq("boot_shift_cycles", 64'(sh_cycles), 64'd56);
        repeat (5) @(negedge clk);
        check_eq("boot_no_ack", 64'(n_acks), 64'd0);
        check_eq("boot_idle", 64'(busy), 64'd0);

        // Single requests, match and mismatch on both requesters
        do_req(0, SIM,              1'b1, "req0_match");
        do_req(1, SIM ^ 57'h1,      1'b0, "req1_miss");
        do_req(1, SIM,              1'b1, "req1_match");
        do_req(0, SIM ^ 57'h1,      1'b0, "req0_miss");

        // Both requests held through reset: boot first, then 0,1,0,1
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        model_match = '0;
        expected_dna = {SIM, SIM};
        req = 2'b11;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) sb.push_back('{k % 2, 1'b1});
        rst = 1'b0;
        base = n_acks;
        wait_ack(base, 400, edges);
        check_eq("held_first_ack_edges", 64'(edges), 64'(BOOT_EDGES + LAT));
        edges = 0;
        while (n_acks < base + 4 && edges < 1000) begin
            @(posedge clk);
            #2;
            edges++;
        end
        req = '0;
        check_eq("held_ack_count", 64'(n_acks - base), 64'd4);

        // Reset in the middle of the boot shift, with a request pending
        wait_idle("midshift");
        rst = 1'b1;
        sb.delete();
        model_match = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (22) @(posedge clk);
        @(negedge clk);
        check_eq("midshift_active", 64'(dut.dna_shift), 64'd1);
        expected_dna[0 +: W] = SIM;
        req[0] = 1'b1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_reset_outputs("midshift_rst");
            @(negedge clk);
        end
        rst = 1'b0;
        rd_cycles = 0;
        sh_cycles = 0;
        sb.push_back('{0, 1'b1});
        base = n_acks;
        wait_ack(base, 400, edges);
        req[0] = 1'b0;
        check_eq("midshift_ack_edges", 64'(edges), 64'(BOOT_EDGES + LAT));
        check_eq("midshift_dna_value", 64'(dna_value), 64'(SIM));
        check_eq("midshift_read_cycles", 64'(rd_cycles), 64'(READS));
        check_eq("midshift_shift_cycles", 64'(sh_cycles), 64'(56 * READS));

        // One-cycle request pulse: exactly one transaction
        wait_idle("pulse");
        base = n_acks;
        expected_dna[0 +: W] = SIM ^ (57'h1 << 56);
        req[0] = 1'b1;
        sb.push_back('{0, 1'b0});
        @(negedge clk);
        req[0] = 1'b0;
        edges = 1;
        while (n_acks == base && edges < 300) begin
            @(posedge clk);
            #2;
            edges++;
        end
        check_eq("pulse_latency", 64'(edges), 64'(LAT));
        repeat (150) @(negedge clk);
        check_eq("pulse_single_ack", 64'(n_acks - base), 64'd1);
        check_eq("pulse_idle", 64'(busy), 64'd0);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
